d0fifo_drain: RTL and testbench

- Read-side consumer that sits directly downstream of the zero-latency d0fifo.
- Issues pops to the FIFO and captures each returned word into a 2-entry output buffer.
- Presents the words as a registered valid/ready stream, with packet framing (out_last) and a completed-packet count.
- Decouples d0fifo's combinational read path from downstream timing while sustaining one word per cycle.

---
 rtl/d0fifo_pkg.sv | 18 +
 rtl/d0fifo_skid2.sv | 76 +++++++
 rtl/d0fifo_drain.sv | 94 +++++++++
 tb/tb_d0fifo_drain.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/d0fifo_pkg.sv
// Shared types and helpers for the d0fifo read-side drain logic.
package d0fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } drain_state_t;

  // Beat counter width: clog2(n), never narrower than one bit.
  function automatic int bw(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/d0fifo_skid2.sv
// Two-entry output buffer whose state encodes its occupancy; head is always entry 0.
module d0fifo_skid2
  import d0fifo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               enq,
  input  logic               deq,
  input  logic [WIDTH-1:0]   din,
  output drain_state_t       state_o,
  output logic [WIDTH-1:0]   head_o
);

  drain_state_t     state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  // NOTE: the data registers are reset as well so out_data reads 0 during reset;
  // with only two entries this costs nothing and keeps the output deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    // NOTE: hold values assigned first so no path through this block infers a latch.
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (enq) begin
            state_d = ONE;
            head_d  = din;
          end
        end
        ONE: begin
          if (enq && deq) begin
            head_d = din;
          end else if (enq) begin
            state_d = TWO;
            tail_d  = din;
          end else if (deq) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // An enq here without deq is an overflow; the word is simply not stored.
          if (deq) begin
            state_d = ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign state_o = state_q;
  assign head_o  = head_q;

endmodule

// File: rtl/d0fifo_drain.sv
// Read-side consumer of d0fifo: pops into a 2-entry buffer and presents a framed,
// registered valid/ready stream with a completed-packet count and overflow flag.
module d0fifo_drain
  import d0fifo_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             err_ovf
);

  localparam int BW = bw(PKT_LEN);

  drain_state_t     state;
  logic [WIDTH-1:0] head;
  logic             enq;
  logic             deq;

  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             err_q, err_d;

  assign enq = fifo_valid & ~flush;
  assign deq = out_valid & out_ready;

  d0fifo_skid2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .enq     (enq),
    .deq     (deq),
    .din     (fifo_rdata),
    .state_o (state),
    .head_o  (head)
  );

  // Pop depends only on registered occupancy, so out_ready never reaches the FIFO.
  assign fifo_pop  = ~fifo_empty & (state != TWO) & ~flush & ~rst;
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign out_last  = out_valid & (beat_q == BW'(PKT_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q    <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    beat_d    = beat_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = err_q;
    if (flush) begin
      beat_d    = '0;
      pkt_cnt_d = '0;
      err_d     = 1'b0;
    end else begin
      if (deq) begin
        if (out_last) begin
          beat_d    = '0;
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      if (fifo_valid && (state == TWO) && !deq) err_d = 1'b1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_ovf = err_q;

endmodule

// File: tb/tb_d0fifo_drain.sv
// Scoreboard bench for d0fifo_drain: a PKT_LEN=8 instance for directed tests and a
// PKT_LEN=1 instance for random-backpressure streaming; each fed by a d0fifo model.
module tb_d0fifo_drain;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic inj;
  logic [15:0] inj_data;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instance 0: PKT_LEN = 8 ----------------
  logic        fifo_empty0, fifo_valid0, fifo_pop0;
  logic [15:0] fifo_rdata0, out_data0, pkt_cnt0;
  logic        out_valid0, out_ready0, out_last0, err_ovf0;
  logic [15:0] mem0 [256];
  int          wr0 = 0, rd0 = 0, pos0 = 0;
  exp_t        exp0 [$];

  assign fifo_empty0 = (rd0 == wr0);
  assign fifo_valid0 = (fifo_pop0 & ~fifo_empty0) | inj;
  assign fifo_rdata0 = inj ? inj_data : mem0[rd0[7:0]];

  always @(posedge clk) begin
    if (flush) rd0 <= wr0;
    else if (fifo_pop0 && !fifo_empty0) rd0 <= rd0 + 1;
  end

  d0fifo_drain #(.WIDTH(16), .PKT_LEN(8), .CNT_W(16)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_empty (fifo_empty0),
    .fifo_valid (fifo_valid0),
    .fifo_rdata (fifo_rdata0),
    .fifo_pop   (fifo_pop0),
    .out_valid  (out_valid0),
    .out_ready  (out_ready0),
    .out_data   (out_data0),
    .out_last   (out_last0),
    .pkt_cnt    (pkt_cnt0),
    .err_ovf    (err_ovf0)
  );

  always @(negedge clk) begin
    if (!rst && !flush && out_valid0 && out_ready0) begin
      if (exp0.size() == 0) begin
        check("dut0 unexpected word", {16'h0, out_data0}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp0.pop_front();
        check("dut0 data", {16'h0, out_data0}, {16'h0, e.data});
        check("dut0 last", {31'h0, out_last0}, {31'h0, e.last});
      end
    end
  end

  // ---------------- instance 1: PKT_LEN = 1 ----------------
  logic        fifo_empty1, fifo_valid1, fifo_pop1;
  logic [15:0] fifo_rdata1, out_data1, pkt_cnt1;
  logic        out_valid1, out_ready1, out_last1, err_ovf1;
  logic [15:0] mem1 [256];
  int          wr1 = 0, rd1 = 0;
  exp_t        exp1 [$];

  assign fifo_empty1 = (rd1 == wr1);
  assign fifo_valid1 = fifo_pop1 & ~fifo_empty1;
  assign fifo_rdata1 = mem1[rd1[7:0]];

  always @(posedge clk) begin
    if (flush) rd1 <= wr1;
    else if (fifo_pop1 && !fifo_empty1) rd1 <= rd1 + 1;
  end

  d0fifo_drain #(.WIDTH(16), .PKT_LEN(1), .CNT_W(16)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_empty (fifo_empty1),
    .fifo_valid (fifo_valid1),
    .fifo_rdata (fifo_rdata1),
    .fifo_pop   (fifo_pop1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .out_data   (out_data1),
    .out_last   (out_last1),
    .pkt_cnt    (pkt_cnt1),
    .err_ovf    (err_ovf1)
  );

  always @(negedge clk) begin
    if (!rst) begin
      check("dut1 last==valid", {31'h0, out_last1}, {31'h0, out_valid1});
      if (!flush && out_valid1 && out_ready1) begin
        if (exp1.size() == 0) begin
          check("dut1 unexpected word", {16'h0, out_data1}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp1.pop_front();
          check("dut1 data", {16'h0, out_data1}, {16'h0, e.data});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [15:0] d);
    exp_t e;
    mem0[wr0[7:0]] = d;
    wr0++;
    e.data = d;
    e.last = ((pos0 % 8) == 7);
    exp0.push_back(e);
    pos0++;
  endtask

  task automatic push1(input logic [15:0] d);
    exp_t e;
    mem1[wr1[7:0]] = d;
    wr1++;
    e.data = d;
    e.last = 1'b1;
    exp1.push_back(e);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    exp0.delete();
    exp1.delete();
    pos0 = 0;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain0(input string name, input int budget);
    int n;
    n = 0;
    while (exp0.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp0.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    rst        = 1'b1;
    flush      = 1'b0;
    inj        = 1'b0;
    inj_data   = 16'h0;
    out_ready0 = 1'b1;
    out_ready1 = 1'b0;

    // 1: reset with a non-empty FIFO
    push0(16'hA5A5);
    repeat (2) @(negedge clk);
    check("t1 pop in reset", {31'h0, fifo_pop0}, 0);
    check("t1 valid in reset", {31'h0, out_valid0}, 0);
    check("t1 data in reset", {16'h0, out_data0}, 0);
    check("t1 pkt_cnt in reset", {16'h0, pkt_cnt0}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t1 pop after release", {31'h0, fifo_pop0}, 1);
    check("t1 valid after release", {31'h0, out_valid0}, 0);
    @(negedge clk);
    check("t1 valid next cycle", {31'h0, out_valid0}, 1);
    tick();
    do_flush();

    // 2: 16-word stream at full rate, two packets
    for (int i = 1; i <= 16; i++) push0(16'(i));
    repeat (17) tick();
    check("t2 one word per cycle", exp0.size(), 0);
    check("t2 pkt_cnt", {16'h0, pkt_cnt0}, 2);
    check("t2 valid idle", {31'h0, out_valid0}, 0);

    // 3: backpressure stops pops at two
    out_ready0 = 1'b0;
    s = rd0;
    for (int i = 1; i <= 4; i++) push0(16'h0100 + 16'(i));
    repeat (5) tick();
    check("t3 pop count", rd0 - s, 2);
    check("t3 pop stalled", {31'h0, fifo_pop0}, 0);
    check("t3 head held", {16'h0, out_data0}, 32'h0101);
    out_ready0 = 1'b1;
    drain0("t3 drain", 20);
    check("t3 pops resumed", rd0, wr0);

    // 4: overflow injection in TWO
    out_ready0 = 1'b0;
    push0(16'h0201);
    push0(16'h0202);
    repeat (3) tick();
    check("t4 head before", {16'h0, out_data0}, 32'h0201);
    inj      = 1'b1;
    inj_data = 16'hDEAD;
    tick();
    inj = 1'b0;
    check("t4 err set", {31'h0, err_ovf0}, 1);
    check("t4 head kept", {16'h0, out_data0}, 32'h0201);
    out_ready0 = 1'b1;
    drain0("t4 drain", 10);
    check("t4 err sticky", {31'h0, err_ovf0}, 1);
    out_ready0 = 1'b0;
    do_flush();
    check("t4 err cleared", {31'h0, err_ovf0}, 0);

    // 5: flush mid-packet at beat 5 with occupancy TWO
    out_ready0 = 1'b1;
    for (int i = 1; i <= 8; i++) push0(16'h0300 + 16'(i));
    repeat (5) tick();
    out_ready0 = 1'b0;
    repeat (2) tick();
    check("t5 head beat5", {16'h0, out_data0}, 32'h0305);
    check("t5 full no pop", {31'h0, fifo_pop0}, 0);
    do_flush();
    check("t5 valid after flush", {31'h0, out_valid0}, 0);
    check("t5 pkt_cnt after flush", {16'h0, pkt_cnt0}, 0);
    out_ready0 = 1'b1;
    for (int i = 1; i <= 8; i++) push0(16'h0400 + 16'(i));
    drain0("t5 drain", 20);
    check("t5 pkt_cnt", {16'h0, pkt_cnt0}, 1);

    // 6: PKT_LEN=1, random backpressure over 100 words
    for (int i = 0; i < 100; i++) push1(16'h1000 + 16'(i));
    n = 0;
    while (exp1.size() != 0 && n < 2000) begin
      out_ready1 = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready1 = 1'b0;
    tick();
    check("t6 drain", exp1.size(), 0);
    check("t6 pkt_cnt", {16'h0, pkt_cnt1}, 100);
    check("t6 all popped", rd1, wr1);
    check("t6 no err", {31'h0, err_ovf1}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
